pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the five-stage RV64 pipeline. It observes operand hazards, EX-stage redirects and memory-port busy signals, and drives the PC update and the per-register hold/bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM defers a redirect while an instruction fetch is still outstanding, so wrong-path fetches are dropped and the redirect target is not lost.

## Interface
Parameters:
- XLEN, 64, PC/target width
- REG_AW, 5, register-index width

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low (0 = reset)
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1 / rs2
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_mem_read  in  1  the instruction in EX is a load
- ex_redirect  in  1  EX resolved a taken branch/jump or a mispredict
- ex_redirect_target  in  XLEN  correct next PC
- imem_busy  in  1  fetch outstanding; IF data not valid
- dmem_busy  in  1  MEM-stage access outstanding
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble (NOP, valid=0) on the next edge
- pc_redirect  out  1  PC loads pc_redirect_target
- pc_redirect_target  out  XLEN  redirect address
- ctrl_state  out  2  FSM state, for debug
- perf_stall_cycles, perf_flush_count, perf_loaduse_count  out  32  performance counters

## Operation
FSM states (2-bit encoding): RUN=0, REDIR_WAIT=1, DSTALL=2.

Priority is evaluated every cycle, from highest to lowest:
1. **dmem_busy=1** (any state):
   - pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_en=1; mem_wb_flush=1; no redirect is issued.
   - From RUN, go to DSTALL. REDIR_WAIT stays in REDIR_WAIT.
2. **REDIR_WAIT, imem_busy=1**: pc_en=0; if_id_flush=1; all other stages advance.
3. **REDIR_WAIT, imem_busy=0**:
   - pc_redirect=1 with the held target; pc_en=1; if_id_flush=1 (drops the wrong-path word).
   - Go to RUN.
4. **ex_redirect=1**:
   - if_id_flush=1, id_ex_flush=1.
   - If imem_busy=0: pc_redirect=1, pc_redirect_target=ex_redirect_target, pc_en=1.
   - If imem_busy=1: latch the target, pc_en=0, go to REDIR_WAIT.
5. **Load-use hazard**: ex_mem_read and ex_rd≠0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
   - Response: pc_en=0, if_id_en=0, id_ex_flush=1.
6. **imem_busy=1**: pc_en=0; if_id_flush=1; downstream stages advance.
7. **Otherwise**: all enables 1, all flushes 0.

Additional rules:
- DSTALL returns to RUN in the first cycle dmem_busy=0; that cycle is evaluated from rule 4 down.
- A flush overrides the same register's enable: the register loads the bubble.
- A redirect and a load-use hazard in the same cycle: the redirect wins and no load-use stall is applied.
- In REDIR_WAIT, ex_redirect is ignored, because EX holds a bubble.

## Timing
- All control outputs are combinational from the current inputs and the FSM state, and act on the next rising edge.
- The held target and the FSM are registered.
- Load-use stall lasts exactly 1 cycle.
- Redirect latency: 0 cycles if imem_busy=0; otherwise pc_redirect rises in the first cycle with imem_busy=0.
- Reset asserted (reset=0), asynchronously:
  - FSM=RUN; held target=0; counters=0.
  - All *_en=0; all *_flush=1; pc_redirect=0; pc_redirect_target=0; ctrl_state=0.
- Reset mid-REDIR_WAIT discards the pending redirect.

## Configuration
- **PIPE_HAZARD_CTRL_PERF_EN defined**: the three counters are live and saturate at 2^32−1.
  - perf_stall_cycles increments on each cycle with pc_en=0 outside reset.
  - perf_flush_count increments on each cycle with if_id_flush due to a redirect (rules 3 and 4).
  - perf_loaduse_count increments on each rule-5 stall.
- **Macro undefined**: the ports remain and are tied to 0; no counter flops are built.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum typedef pipe_ctrl_state_t;
  - the XLEN and REG_AW defaults;
  - a NOP instruction constant (0x00000013) shared with the pipeline registers.
- Sub-module pipe_perf_counters (saturating 32-bit counters) is instantiated only under the macro.

## Test plan
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → 1 cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle all enables are 1. perf_loaduse_count=1.
- Same as above but ex_rd=0 → no stall.
- ex_redirect=1, target=0x8000_0100, imem_busy=0 → pc_redirect=1 with target 0x8000_0100, if_id_flush=id_ex_flush=1, same cycle.
- ex_redirect=1, target=0x8000_0200, imem_busy=1 for 3 cycles → ctrl_state=1 with pc_en=0 for 3 cycles. Cycle 4: pc_redirect=1 with target 0x8000_0200, if_id_flush=1, then RUN.
- dmem_busy=1 for 4 cycles while ex_redirect=1 → 4 cycles with front enables 0, mem_wb_flush=1, ctrl_state=2, no redirect. Cycle 5: redirect issued.
- reset pulled low during REDIR_WAIT → immediately ctrl_state=0, pc_redirect=0, all flushes 1. After release, no redirect is issued.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and pipeline registers.
package pipe_ctrl_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned REG_AW_DEF = 5;

  // addi x0, x0, 0 -- loaded into a pipeline register when it is flushed
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REDIR_WAIT = 2'd1,
    ST_DSTALL     = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
    logic pc_redirect;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    default: 1'b0
  };

  localparam pipe_ctrl_t CTRL_RESET = '{
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1, mem_wb_flush: 1'b1,
    default: 1'b0
  };

endpackage

// File: rtl/pipe_perf_counters.sv
// Saturating 32-bit stall/flush/load-use event counters.
// Only built when PIPE_HAZARD_CTRL_PERF_EN is defined.
`ifdef PIPE_HAZARD_CTRL_PERF_EN
module pipe_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_stall_i,
  input  logic        inc_flush_i,
  input  logic        inc_loaduse_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] loaduse_cnt_o
);

  logic [2:0]       inc;
  logic [2:0][31:0] cnt_q, cnt_d;

  assign inc = {inc_loaduse_i, inc_flush_i, inc_stall_i};

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (inc[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign stall_cnt_o   = cnt_q[0];
  assign flush_cnt_o   = cnt_q[1];
  assign loaduse_cnt_o = cnt_q[2];

endmodule
`endif

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline; defers redirects behind outstanding fetches.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the performance counters (otherwise tied to 0).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic [XLEN-1:0]   ex_redirect_target,
  input  logic              imem_busy,
  input  logic              dmem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   pc_redirect_target,
  output logic [1:0]        ctrl_state,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count,
  output logic [31:0]       perf_loaduse_count
);

  pipe_ctrl_state_t state_q, state_d;
  logic [XLEN-1:0]  held_q, held_d;
  logic [XLEN-1:0]  tgt_c;
  pipe_ctrl_t       ctl_c, ctl;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    ctl_c   = CTRL_RUN;
    tgt_c   = '0;
    state_d = state_q;
    held_d  = held_q;
    if (dmem_busy) begin
      ctl_c.pc_en        = 1'b0;
      ctl_c.if_id_en     = 1'b0;
      ctl_c.id_ex_en     = 1'b0;
      ctl_c.ex_mem_en    = 1'b0;
      ctl_c.mem_wb_flush = 1'b1;
      if (state_q == ST_RUN) state_d = ST_DSTALL;
    end else if (state_q == ST_REDIR_WAIT) begin
      // EX holds a bubble here, so ex_redirect is deliberately not consulted
      ctl_c.if_id_flush = 1'b1;
      if (imem_busy) begin
        ctl_c.pc_en = 1'b0;
      end else begin
        ctl_c.pc_redirect = 1'b1;
        tgt_c             = held_q;
        state_d           = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (ex_redirect) begin
        ctl_c.if_id_flush = 1'b1;
        ctl_c.id_ex_flush = 1'b1;
        if (imem_busy) begin
          ctl_c.pc_en = 1'b0;
          held_d      = ex_redirect_target;
          state_d     = ST_REDIR_WAIT;
        end else begin
          ctl_c.pc_redirect = 1'b1;
          tgt_c             = ex_redirect_target;
        end
      end else if (load_use) begin
        ctl_c.pc_en       = 1'b0;
        ctl_c.if_id_en    = 1'b0;
        ctl_c.id_ex_flush = 1'b1;
      end else if (imem_busy) begin
        ctl_c.pc_en       = 1'b0;
        ctl_c.if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end

  assign ctl = reset ? ctl_c : CTRL_RESET;

  assign pc_en              = ctl.pc_en;
  assign if_id_en           = ctl.if_id_en;
  assign id_ex_en           = ctl.id_ex_en;
  assign ex_mem_en          = ctl.ex_mem_en;
  assign mem_wb_en          = ctl.mem_wb_en;
  assign if_id_flush        = ctl.if_id_flush;
  assign id_ex_flush        = ctl.id_ex_flush;
  assign ex_mem_flush       = ctl.ex_mem_flush;
  assign mem_wb_flush       = ctl.mem_wb_flush;
  assign pc_redirect        = ctl.pc_redirect;
  assign pc_redirect_target = reset ? tgt_c : '0;
  assign ctrl_state         = state_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic inc_flush, inc_loaduse;

  // Events are taken from the pre-reset control terms; the counters are held in reset anyway.
  assign inc_flush   = !dmem_busy && ((state_q == ST_REDIR_WAIT) ? !imem_busy : ex_redirect);
  assign inc_loaduse = !dmem_busy && (state_q != ST_REDIR_WAIT) && !ex_redirect && load_use;

  pipe_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (reset),
    .inc_stall_i  (!ctl_c.pc_en),
    .inc_flush_i  (inc_flush),
    .inc_loaduse_i(inc_loaduse),
    .stall_cnt_o  (perf_stall_cycles),
    .flush_cnt_o  (perf_flush_count),
    .loaduse_cnt_o(perf_loaduse_count)
  );
`else
  assign perf_stall_cycles  = '0;
  assign perf_flush_count   = '0;
  assign perf_loaduse_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a rule-priority reference model.
module tb_pipe_hazard_ctrl;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic [XLEN-1:0]   ex_redirect_target;
  logic              imem_busy, dmem_busy;
  logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic              pc_redirect;
  logic [XLEN-1:0]   pc_redirect_target;
  logic [1:0]        ctrl_state;
  logic [31:0]       perf_stall_cycles, perf_flush_count, perf_loaduse_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_redirect_target(ex_redirect_target), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_redirect(pc_redirect),
    .pc_redirect_target(pc_redirect_target), .ctrl_state(ctrl_state),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
    .perf_loaduse_count(perf_loaduse_count)
  );

  // ctl: {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_fl,id_ex_fl,ex_mem_fl,mem_wb_fl,redirect}
  typedef struct packed {
    logic [9:0]      ctl;
    logic [XLEN-1:0] tgt;
    logic [1:0]      st;
    logic [31:0]     cs;
    logic [31:0]     cf;
    logic [31:0]     cl;
  } obs_t;

  int total = 0;
  int bad   = 0;

  // reference model state: a pending redirect and a data-stall flag
  bit              m_pending, m_dstall;
  logic [XLEN-1:0] m_held;
  int unsigned     m_cs, m_cf, m_cl;
  obs_t            exp_o, got;
  bit              nx_pending, nx_dstall, inc_s, inc_f, inc_l;
  logic [XLEN-1:0] nx_held;

  function automatic obs_t dut_obs();
    obs_t o;
    o.ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect};
    o.tgt = pc_redirect_target;
    o.st  = ctrl_state;
    o.cs  = perf_stall_cycles;
    o.cf  = perf_flush_count;
    o.cl  = perf_loaduse_count;
    return o;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_dstall = 0; m_held = '0;
    m_cs = 0; m_cf = 0; m_cl = 0;
  endtask

  task automatic model_eval();
    bit pc, ifid, idex, exmem, memwb, fif, fidex, fexmem, fmemwb, rd, hazard;
    logic [XLEN-1:0] t;
    pc = 1; ifid = 1; idex = 1; exmem = 1; memwb = 1;
    fif = 0; fidex = 0; fexmem = 0; fmemwb = 0; rd = 0; t = '0;
    nx_pending = m_pending; nx_dstall = m_dstall; nx_held = m_held;
    inc_f = 0; inc_l = 0;
    hazard = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (!reset) begin
      pc = 0; ifid = 0; idex = 0; exmem = 0; memwb = 0;
      fif = 1; fidex = 1; fexmem = 1; fmemwb = 1;
    end else if (dmem_busy) begin
      pc = 0; ifid = 0; idex = 0; exmem = 0; fmemwb = 1;
      nx_dstall = !m_pending;
    end else if (m_pending) begin
      fif = 1;
      if (imem_busy) pc = 0;
      else begin rd = 1; t = m_held; nx_pending = 0; inc_f = 1; end
    end else begin
      nx_dstall = 0;
      if (ex_redirect) begin
        fif = 1; fidex = 1; inc_f = 1;
        if (!imem_busy) begin rd = 1; t = ex_redirect_target; end
        else begin pc = 0; nx_pending = 1; nx_held = ex_redirect_target; end
      end else if (hazard) begin
        pc = 0; ifid = 0; fidex = 1; inc_l = 1;
      end else if (imem_busy) begin
        pc = 0; fif = 1;
      end
    end
    inc_s = reset && !pc;
    exp_o.ctl = {pc, ifid, idex, exmem, memwb, fif, fidex, fexmem, fmemwb, rd};
    exp_o.tgt = t;
    exp_o.st  = !reset ? 2'd0 : m_pending ? 2'd1 : m_dstall ? 2'd2 : 2'd0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    exp_o.cs = m_cs; exp_o.cf = m_cf; exp_o.cl = m_cl;
`else
    exp_o.cs = 0; exp_o.cf = 0; exp_o.cl = 0;
`endif
  endtask

  task automatic model_commit();
    if (!reset) model_reset();
    else begin
      m_pending = nx_pending; m_dstall = nx_dstall; m_held = nx_held;
      if (inc_s && m_cs != 32'hFFFF_FFFF) m_cs++;
      if (inc_f && m_cf != 32'hFFFF_FFFF) m_cf++;
      if (inc_l && m_cl != 32'hFFFF_FFFF) m_cl++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic settle();
    model_eval();
    #3;
  endtask

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_read = 0; ex_redirect = 0;
    ex_redirect_target = '0; imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic test_reset();
    reset = 0; idle_inputs(); model_reset();
    #2; settle();
    got = dut_obs();
    total++; if (got !== exp_o) $display("FAIL reset_model: got=%h want=%h", got, exp_o);
    if (got !== exp_o) bad++;
    total++;
    if ({got.ctl, got.tgt, got.st} !== {10'b0000011110, 64'd0, 2'd0}) begin
      bad++; $display("FAIL reset_outputs: got ctl=%b tgt=%h st=%0d want ctl=0000011110 tgt=0 st=0",
                      got.ctl, got.tgt, got.st);
    end
    advance(); advance();
    reset = 1;
  endtask

  task automatic test_loaduse();
    idle_inputs(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    settle(); got = dut_obs();
    total++; if (got !== exp_o) begin bad++; $display("FAIL loaduse_model: got=%h want=%h", got, exp_o); end
    total++;
    if ({pc_en, if_id_en, id_ex_flush} !== 3'b001) begin
      bad++; $display("FAIL loaduse_stall: got pc/ifid_en/idex_fl=%b want 001", {pc_en, if_id_en, id_ex_flush});
    end
    advance();
    ex_mem_read = 0;
    settle(); got = dut_obs();
    total++; if (got !== exp_o) begin bad++; $display("FAIL loaduse_after_model: got=%h want=%h", got, exp_o); end
    total++;
    if ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 5'b11111) begin
      bad++; $display("FAIL loaduse_release: got en=%b want 11111", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    total++;
    if (perf_loaduse_count !== 32'd1) begin
      bad++; $display("FAIL loaduse_count: got=%0d want=1", perf_loaduse_count);
    end
`endif
    advance();
  endtask

  task automatic test_loaduse_boundaries();
    idle_inputs(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    settle();
    total++; if (pc_en !== 1'b1 || if_id_en !== 1'b1 || id_ex_flush !== 1'b0) begin
      bad++; $display("FAIL loaduse_x0: got pc/ifid_en/idex_fl=%b want 110", {pc_en, if_id_en, id_ex_flush});
    end
    advance();
    idle_inputs(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; id_rs1 = 7;
    settle(); got = dut_obs();
    total++; if (got !== exp_o || pc_en !== 1'b0 || id_ex_flush !== 1'b1) begin
      bad++; $display("FAIL loaduse_rs2: got=%h want=%h", got, exp_o);
    end
    advance();
    id_uses_rs2 = 0;
    settle();
    total++; if (pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin
      bad++; $display("FAIL loaduse_unused_reg: got pc_en=%b idex_fl=%b want 1 0", pc_en, id_ex_flush);
    end
    advance();
  endtask

  task automatic test_redirect_now();
    idle_inputs(); ex_redirect = 1; ex_redirect_target = 64'h8000_0100;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    settle(); got = dut_obs();
    total++; if (got !== exp_o) begin bad++; $display("FAIL redirect_now_model: got=%h want=%h", got, exp_o); end
    total++;
    if ({pc_en, pc_redirect, if_id_flush, id_ex_flush} !== 4'b1111 || pc_redirect_target !== 64'h8000_0100) begin
      bad++; $display("FAIL redirect_now: got pc/redir/iffl/idfl=%b tgt=%h want 1111 tgt=80000100",
                      {pc_en, pc_redirect, if_id_flush, id_ex_flush}, pc_redirect_target);
    end
    advance();
  endtask

  task automatic test_redirect_wait();
    for (int c = 1; c <= 5; c++) begin
      idle_inputs();
      if (c == 1) begin ex_redirect = 1; ex_redirect_target = 64'h8000_0200; imem_busy = 1; end
      if (c == 2 || c == 3) begin ex_redirect = 1; ex_redirect_target = 64'hDEAD_0000; imem_busy = 1; end
      settle(); got = dut_obs();
      total++; if (got !== exp_o) begin bad++; $display("FAIL redirect_wait_model c%0d: got=%h want=%h", c, got, exp_o); end
      total++;
      if (c <= 3 && (pc_en !== 1'b0 || pc_redirect !== 1'b0 || ctrl_state !== ((c == 1) ? 2'd0 : 2'd1))) begin
        bad++; $display("FAIL redirect_wait_hold c%0d: got pc_en=%b redir=%b st=%0d", c, pc_en, pc_redirect, ctrl_state);
      end else if (c == 4 && (pc_redirect !== 1'b1 || pc_redirect_target !== 64'h8000_0200 ||
                              if_id_flush !== 1'b1 || ctrl_state !== 2'd1)) begin
        bad++; $display("FAIL redirect_wait_issue: got redir=%b tgt=%h iffl=%b st=%0d want 1 80000200 1 1",
                        pc_redirect, pc_redirect_target, if_id_flush, ctrl_state);
      end else if (c == 5 && (ctrl_state !== 2'd0 || pc_redirect !== 1'b0)) begin
        bad++; $display("FAIL redirect_wait_done: got st=%0d redir=%b want 0 0", ctrl_state, pc_redirect);
      end
      advance();
    end
  endtask

  task automatic test_dmem_redirect();
    for (int c = 1; c <= 6; c++) begin
      idle_inputs();
      if (c <= 5) begin ex_redirect = 1; ex_redirect_target = 64'h8000_0300; end
      dmem_busy = (c <= 4);
      settle(); got = dut_obs();
      total++; if (got !== exp_o) begin bad++; $display("FAIL dmem_model c%0d: got=%h want=%h", c, got, exp_o); end
      total++;
      if (c <= 4 && ({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_wb_flush, pc_redirect} !== 7'b0000110 ||
                     ctrl_state !== ((c == 1) ? 2'd0 : 2'd2))) begin
        bad++; $display("FAIL dmem_stall c%0d: got en/mwfl/redir=%b st=%0d", c,
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, mem_wb_flush, pc_redirect}, ctrl_state);
      end else if (c == 5 && (pc_redirect !== 1'b1 || pc_redirect_target !== 64'h8000_0300 || ctrl_state !== 2'd2)) begin
        bad++; $display("FAIL dmem_release: got redir=%b tgt=%h st=%0d want 1 80000300 2",
                        pc_redirect, pc_redirect_target, ctrl_state);
      end else if (c == 6 && ctrl_state !== 2'd0) begin
        bad++; $display("FAIL dmem_run: got st=%0d want 0", ctrl_state);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_wait();
    idle_inputs(); ex_redirect = 1; ex_redirect_target = 64'h8000_0400; imem_busy = 1;
    settle(); advance();
    idle_inputs(); imem_busy = 1;
    settle();
    total++; if (ctrl_state !== 2'd1) begin bad++; $display("FAIL midwait_enter: got st=%0d want 1", ctrl_state); end
    reset = 0; model_reset();
    #1; model_eval(); got = dut_obs();
    total++;
    if (got !== exp_o || ctrl_state !== 2'd0 || pc_redirect !== 1'b0 ||
        {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} !== 4'b1111) begin
      bad++; $display("FAIL midwait_reset: got=%h want=%h", got, exp_o);
    end
    advance();
    reset = 1; imem_busy = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      total++; if (pc_redirect !== 1'b0 || ctrl_state !== 2'd0) begin
        bad++; $display("FAIL midwait_dropped c%0d: got redir=%b st=%0d want 0 0", c, pc_redirect, ctrl_state);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) != 0);
      if (!reset) model_reset();
      id_rs1      = REG_AW'($urandom_range(0, 3));
      id_rs2      = REG_AW'($urandom_range(0, 3));
      ex_rd       = REG_AW'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 3) == 0);
      ex_redirect_target = {$urandom, $urandom};
      imem_busy   = ($urandom_range(0, 9) < 4);
      dmem_busy   = ($urandom_range(0, 9) < 2);
      settle(); got = dut_obs();
      total++;
      if (got !== exp_o) begin
        bad++; $display("FAIL random n=%0d: got ctl=%b tgt=%h st=%0d cnt=%0d/%0d/%0d want ctl=%b tgt=%h st=%0d cnt=%0d/%0d/%0d",
                        n, got.ctl, got.tgt, got.st, got.cs, got.cf, got.cl,
                        exp_o.ctl, exp_o.tgt, exp_o.st, exp_o.cs, exp_o.cf, exp_o.cl);
      end
      advance();
    end
    reset = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loaduse();
    test_loaduse_boundaries();
    test_redirect_now();
    test_redirect_wait();
    test_dmem_redirect();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
